// File: rtl/rv_mem_pkg.sv
// Shared encodings for the MEM stage: load/store size codes and the
// memory-handshake FSM states.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for the data port: byte enables and replicated
// store data, load extraction with sign/zero extension, misalignment detect.
module load_store_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half out of the returned word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo_i)
            2'd0:    byte_s = load_word_i[7:0];
            2'd1:    byte_s = load_word_i[15:8];
            2'd2:    byte_s = load_word_i[23:16];
            2'd3:    byte_s = load_word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = load_word_i[31:16];
        end else begin
            half_s = load_word_i[15:0];
        end
    end

    // Size-dependent formatting; any unlisted funct3 behaves as a word access.
    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = load_word_i;
        misalign_o  = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
                if (funct3_i == F3_B) begin
                    load_data_o = {{24{byte_s[7]}}, byte_s};
                end else begin
                    load_data_o = {24'h000000, byte_s};
                end
            end
            F3_H, F3_HU: begin
                misalign_o = addr_lo_i[0];
                if (addr_lo_i[1]) begin
                    be_o = 4'b1100;
                end else begin
                    be_o = 4'b0011;
                end
                wdata_o = {2{store_data_i[15:0]}};
                if (funct3_i == F3_H) begin
                    load_data_o = {{16{half_s[15]}}, half_s};
                end else begin
                    load_data_o = {16'h0000, half_s};
                end
            end
            default: begin
                misalign_o  = (addr_lo_i != 2'b00);
                be_o        = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = load_word_i;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// RISC-V MEM stage: ready-handshaked data-memory port with timeout abort,
// upstream stall generation and the MEM/WB pipeline register.
module memory_access_stage
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        Reg_w_i,
    input  logic        M_to_R_i,
    input  logic        Mem_W_i,
    input  logic        Mem_Rd_i,
    input  logic        Jal_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] ALU_result_i,
    input  logic [31:0] Reg2_data_i,
    input  logic [4:0]  RegD_i,
    input  logic [31:0] PC_p4_i,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    output logic        stall_o,
    output logic        Reg_w_o,
    output logic        M_to_R_o,
    output logic        Jal_o,
    output logic [4:0]  RegD_o,
    output logic [31:0] ALU_result_o,
    output logic [31:0] Mem_data_o,
    output logic [31:0] PC_p4_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        mem_op_s;
    logic        misalign_s;
    logic [31:0] load_data_s;
    logic        req_s;
    logic        stall_s;
    logic        latch_s;
    logic        abort_s;
    logic        drop_s;

    logic        reg_w_q;
    logic        m_to_r_q;
    logic        jal_q;
    logic [4:0]  regd_q;
    logic [31:0] alu_q;
    logic [31:0] mem_data_q;
    logic [31:0] pc_p4_q;
    logic        misalign_q;
    logic        bus_err_q;

    assign mem_op_s = Mem_Rd_i | Mem_W_i;

    load_store_align u_align (
        .funct3_i     (funct3_i),
        .addr_lo_i    (ALU_result_i[1:0]),
        .store_data_i (Reg2_data_i),
        .load_word_i  (dmem_rdata_i),
        .be_o         (dmem_be_o),
        .wdata_o      (dmem_wdata_o),
        .load_data_o  (load_data_s),
        .misalign_o   (misalign_s)
    );

    // FSM state and wait-cycle counter.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter WAIT on an aligned access the memory did not accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_s && !misalign_s && !dmem_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ready_i || (cnt_q == CNT_LIMIT)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port and pipeline control; reset kills the request in the same cycle.
    always_comb begin
        req_s   = 1'b0;
        stall_s = 1'b0;
        latch_s = 1'b0;
        abort_s = 1'b0;
        drop_s  = 1'b0;
        if (!reset_i) begin
            req_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!mem_op_s) begin
                        latch_s = 1'b1;
                    end else if (misalign_s) begin
                        drop_s = 1'b1;
                    end else begin
                        req_s   = 1'b1;
                        latch_s = dmem_ready_i;
                        stall_s = !dmem_ready_i;
                    end
                end
                ST_WAIT: begin
                    req_s = 1'b1;
                    if (dmem_ready_i) begin
                        latch_s = 1'b1;
                    end else if (cnt_q == CNT_LIMIT) begin
                        abort_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                    end
                end
                default: begin
                    req_s = 1'b0;
                end
            endcase
        end
    end

    assign dmem_req_o  = req_s;
    assign dmem_we_o   = Mem_W_i & req_s;
    assign dmem_addr_o = {ALU_result_i[31:2], 2'b00};
    assign stall_o     = stall_s;

    // MEM/WB register: bubbles clear only the control bits, data fields hold.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            reg_w_q    <= 1'b0;
            m_to_r_q   <= 1'b0;
            jal_q      <= 1'b0;
            regd_q     <= 5'd0;
            alu_q      <= 32'h0000_0000;
            mem_data_q <= 32'h0000_0000;
            pc_p4_q    <= 32'h0000_0000;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            misalign_q <= drop_s;
            bus_err_q  <= abort_s;
            if (latch_s) begin
                reg_w_q    <= Reg_w_i;
                m_to_r_q   <= M_to_R_i;
                jal_q      <= Jal_i;
                regd_q     <= RegD_i;
                alu_q      <= ALU_result_i;
                mem_data_q <= load_data_s;
                pc_p4_q    <= PC_p4_i;
            end else begin
                reg_w_q  <= 1'b0;
                m_to_r_q <= 1'b0;
                jal_q    <= 1'b0;
            end
        end
    end

    assign Reg_w_o      = reg_w_q;
    assign M_to_R_o     = m_to_r_q;
    assign Jal_o        = jal_q;
    assign RegD_o       = regd_q;
    assign ALU_result_o = alu_q;
    assign Mem_data_o   = mem_data_q;
    assign PC_p4_o      = pc_p4_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: hand-computed expectations for
// loads, stores, wait states, misalignment, timeout and reset mid-wait.
module tb_memory_access_stage;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        Reg_w_i, M_to_R_i, Mem_W_i, Mem_Rd_i, Jal_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALU_result_i, Reg2_data_i, PC_p4_i, dmem_rdata_i;
    logic [4:0]  RegD_i;
    logic        dmem_ready_i;
    logic        dmem_req_o, dmem_we_o, stall_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        Reg_w_o, M_to_R_o, Jal_o, misalign_o, bus_err_o;
    logic [4:0]  RegD_o;
    logic [31:0] ALU_result_o, Mem_data_o, PC_p4_o;

    int checks_r   = 0;
    int failures_r = 0;
    int n_stall_r;

    memory_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .Reg_w_i(Reg_w_i), .M_to_R_i(M_to_R_i), .Mem_W_i(Mem_W_i),
        .Mem_Rd_i(Mem_Rd_i), .Jal_i(Jal_i), .funct3_i(funct3_i),
        .ALU_result_i(ALU_result_i), .Reg2_data_i(Reg2_data_i),
        .RegD_i(RegD_i), .PC_p4_i(PC_p4_i),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .stall_o(stall_o),
        .Reg_w_o(Reg_w_o), .M_to_R_o(M_to_R_o), .Jal_o(Jal_o),
        .RegD_o(RegD_o), .ALU_result_o(ALU_result_o),
        .Mem_data_o(Mem_data_o), .PC_p4_o(PC_p4_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        Reg_w_i = 1'b0; M_to_R_i = 1'b0; Mem_W_i = 1'b0; Mem_Rd_i = 1'b0;
        Jal_i = 1'b0; funct3_i = 3'b010; ALU_result_i = 32'h0;
        Reg2_data_i = 32'h0; RegD_i = 5'd0; PC_p4_i = 32'h0;
        dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        idle_inputs();
        Mem_Rd_i = 1'b1; Reg_w_i = 1'b1; M_to_R_i = 1'b1; RegD_i = 5'd9;
        funct3_i = f3; ALU_result_i = addr; dmem_rdata_i = rdata; dmem_ready_i = 1'b1;
    endtask

    initial begin
        // 1. reset held two cycles with a load pending
        idle_inputs();
        reset_i = 1'b0; Mem_Rd_i = 1'b1; ALU_result_i = 32'h100;
        step(); step();
        check_val("rst_req", {31'd0, dmem_req_o}, 32'd0);
        check_val("rst_stall", {31'd0, stall_o}, 32'd0);
        check_val("rst_we", {31'd0, dmem_we_o}, 32'd0);
        check_val("rst_ctrl", {29'd0, Reg_w_o, M_to_R_o, Jal_o}, 32'd0);
        check_val("rst_regd", {27'd0, RegD_o}, 32'd0);
        check_val("rst_alu", ALU_result_o, 32'd0);
        check_val("rst_mdata", Mem_data_o, 32'd0);
        check_val("rst_pc", PC_p4_o, 32'd0);
        check_val("rst_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);
        idle_inputs();
        reset_i = 1'b1;
        step();

        // 2. LW zero-wait
        load(3'b010, 32'h100, 32'hDEADBEEF);
        RegD_i = 5'd5;
        #1;
        check_val("lw_stall", {31'd0, stall_o}, 32'd0);
        check_val("lw_req", {31'd0, dmem_req_o}, 32'd1);
        check_val("lw_addr", dmem_addr_o, 32'h100);
        step();
        check_val("lw_data", Mem_data_o, 32'hDEADBEEF);
        check_val("lw_regd", {27'd0, RegD_o}, 32'd5);
        check_val("lw_ctrl", {30'd0, Reg_w_o, M_to_R_o}, 32'd3);

        // 3. byte / half loads
        load(3'b000, 32'h103, 32'h80112233);
        step();
        check_val("lb", Mem_data_o, 32'hFFFFFF80);
        load(3'b100, 32'h103, 32'h80112233);
        step();
        check_val("lbu", Mem_data_o, 32'h00000080);
        load(3'b101, 32'h102, 32'h80112233);
        step();
        check_val("lhu", Mem_data_o, 32'h00008011);
        load(3'b001, 32'h100, 32'h1234F00D);
        step();
        check_val("lh", Mem_data_o, 32'hFFFFF00D);

        // non-memory op passes straight through
        idle_inputs();
        Jal_i = 1'b1; Reg_w_i = 1'b1; RegD_i = 5'd7;
        ALU_result_i = 32'h0000_1234; PC_p4_i = 32'h0000_0044;
        #1;
        check_val("alu_req", {31'd0, dmem_req_o}, 32'd0);
        step();
        check_val("alu_ctrl", {29'd0, Reg_w_o, M_to_R_o, Jal_o}, 32'd5);
        check_val("alu_res", ALU_result_o, 32'h0000_1234);
        check_val("alu_pc", PC_p4_o, 32'h0000_0044);

        // SB zero-wait at byte lane 1
        idle_inputs();
        Mem_W_i = 1'b1; funct3_i = 3'b000; ALU_result_i = 32'h201;
        Reg2_data_i = 32'h000000AB; dmem_ready_i = 1'b1;
        #1;
        check_val("sb_be", {28'd0, dmem_be_o}, 32'h2);
        check_val("sb_wdata", dmem_wdata_o, 32'hABABABAB);
        check_val("sb_we", {31'd0, dmem_we_o}, 32'd1);
        step();

        // 4. SH with three wait cycles
        idle_inputs();
        Mem_W_i = 1'b1; funct3_i = 3'b001; ALU_result_i = 32'h202;
        Reg2_data_i = 32'h00001234;
        n_stall_r = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) dmem_ready_i = 1'b1;
            #1;
            if (stall_o) n_stall_r = n_stall_r + 1;
            check_val("sh_port", {dmem_be_o, 3'd0, dmem_req_o, 7'd0, dmem_we_o, 16'd0},
                      {4'b1100, 3'd0, 1'b1, 7'd0, 1'b1, 16'd0});
            check_val("sh_addr", dmem_addr_o, 32'h200);
            check_val("sh_wdata", dmem_wdata_o, 32'h12341234);
            step();
            check_val("sh_regw", {31'd0, Reg_w_o}, 32'd0);
        end
        check_val("sh_nstall", n_stall_r, 32'd3);
        idle_inputs();
        #1;
        check_val("sh_done_stall", {31'd0, stall_o}, 32'd0);

        // 5. misaligned LW
        idle_inputs();
        Mem_Rd_i = 1'b1; Reg_w_i = 1'b1; funct3_i = 3'b010; ALU_result_i = 32'h101;
        #1;
        check_val("mis_req", {31'd0, dmem_req_o}, 32'd0);
        check_val("mis_stall", {31'd0, stall_o}, 32'd0);
        step();
        check_val("mis_pulse", {31'd0, misalign_o}, 32'd1);
        check_val("mis_regw", {31'd0, Reg_w_o}, 32'd0);
        idle_inputs();
        step();
        check_val("mis_end", {31'd0, misalign_o}, 32'd0);

        // 6a. timeout
        idle_inputs();
        Mem_Rd_i = 1'b1; Reg_w_i = 1'b1; funct3_i = 3'b010; ALU_result_i = 32'h300;
        n_stall_r = 0;
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            #1;
            if (!stall_o) break;
            n_stall_r = n_stall_r + 1;
            check_val("to_regw", {31'd0, Reg_w_o}, 32'd0);
            step();
        end
        check_val("to_nstall", n_stall_r, TIMEOUT);
        check_val("to_abort_req", {31'd0, dmem_req_o}, 32'd1);
        check_val("to_early_err", {31'd0, bus_err_o}, 32'd0);
        @(posedge clk_i); #1;
        check_val("to_err", {31'd0, bus_err_o}, 32'd1);
        check_val("to_bubble", {31'd0, Reg_w_o}, 32'd0);
        load(3'b010, 32'h104, 32'h0BADF00D);
        #1;
        check_val("to_idle_stall", {31'd0, stall_o}, 32'd0);
        step();
        check_val("to_err_end", {31'd0, bus_err_o}, 32'd0);
        check_val("to_next_load", Mem_data_o, 32'h0BADF00D);

        // 6b. reset in the fourth WAIT cycle
        idle_inputs();
        Mem_Rd_i = 1'b1; Reg_w_i = 1'b1; funct3_i = 3'b010; ALU_result_i = 32'h300;
        step(); step(); step(); step();
        check_val("rw_wait_stall", {31'd0, stall_o}, 32'd1);
        reset_i = 1'b0;
        #1;
        check_val("rw_req", {31'd0, dmem_req_o}, 32'd0);
        check_val("rw_stall", {31'd0, stall_o}, 32'd0);
        step();
        check_val("rw_regs", {30'd0, Reg_w_o, bus_err_o}, 32'd0);
        idle_inputs();
        reset_i = 1'b1;
        step();
        check_val("rw_no_err", {31'd0, bus_err_o}, 32'd0);
        check_val("rw_idle_stall", {31'd0, stall_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- MEM stage of the RISC-V pipeline; consumes the EX/MEM register outputs (control bits, ALU result, store data, destination register, PC+4).
- Drives a ready-handshaked data-memory port and formats load and store data for byte, half and word accesses.
- Stalls upstream on memory wait states.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT, 16, max cycles a request may wait for dmem_ready_i before abort (>=2).
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  synchronous reset, active-low
- Reg_w_i  in  1  register write enable from EX/MEM
- M_to_R_i  in  1  write-back selects memory data
- Mem_W_i  in  1  store
- Mem_Rd_i  in  1  load
- Jal_i  in  1  write-back selects PC+4
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALU_result_i  in  32  effective address / ALU result
- Reg2_data_i  in  32  store data
- RegD_i  in  5  destination register
- PC_p4_i  in  32  PC+4
- dmem_ready_i  in  1  memory completes current request this cycle
- dmem_rdata_i  in  32  read word, valid with dmem_ready_i
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  write strobe
- dmem_addr_o  out  32  word-aligned address, ALU_result_i with bits [1:0] forced to 0
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- Reg_w_o, M_to_R_o, Jal_o  out  1 each  MEM/WB control
- RegD_o  out  5  MEM/WB destination register
- ALU_result_o  out  32  MEM/WB ALU result
- Mem_data_o  out  32  MEM/WB formatted load data
- PC_p4_o  out  32  MEM/WB PC+4
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- bus_err_o  out  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Reset (reset_i=0 at a clock edge): FSM to IDLE, counter 0; all registered outputs 0 (Reg_w_o, M_to_R_o, Jal_o, RegD_o, ALU_result_o, Mem_data_o, PC_p4_o, misalign_o, bus_err_o).
- Reset forces the combinational outputs dmem_req_o, dmem_we_o and stall_o to 0 in the same cycle. Reset mid-WAIT abandons the request; no write-back.
- mem_op = Mem_Rd_i | Mem_W_i.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- FSM states: IDLE and WAIT.
- IDLE, aligned mem_op:
  - dmem_req_o=1.
  - If dmem_ready_i=1: zero-wait access; stall_o=0; MEM/WB latches at this edge.
  - Else: stall_o=1 and go to WAIT, counter=1.
- WAIT:
  - dmem_req_o=1 with stable address, be and wdata (inputs are held by the stall).
  - dmem_ready_i=1: stall_o=0, MEM/WB latches, go to IDLE.
  - Else if counter==TIMEOUT: abort; stall_o=0; bus_err_o=1 next cycle; MEM/WB loads a bubble (Reg_w_o=0); go to IDLE.
  - Else: stall_o=1, counter increments.
- Misaligned mem_op in IDLE:
  - No request, no stall.
  - misalign_o=1 next cycle.
  - MEM/WB loads a bubble.
- While stall_o=1, MEM/WB loads a bubble each cycle: Reg_w_o=0, M_to_R_o=0, Jal_o=0, other fields don't-care but held.
- Non-memory op: passes to MEM/WB every cycle. Latency is 1 clock for all ops.
- Store byte enables and data:
  - B: be=1<<addr[1:0], wdata={4{data[7:0]}}.
  - H: be=0011 or 1100, wdata={2{data[15:0]}}.
  - W: be=1111, wdata=data.
  - dmem_we_o=Mem_W_i&dmem_req_o.
- Load formatting:
  - Select byte or half by addr[1:0].
  - Sign-extend for B/H; zero-extend for BU/HU.
  - Registered into Mem_data_o.
- Mem_Rd_i and Mem_W_i both high is illegal; treat as store.
- Undefined funct3 on a mem_op is treated as W.

Decomposition:
- Shared package rv_mem_pkg holds the funct3 size codes (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state encoding (ST_IDLE, ST_WAIT).
- One sub-module, load_store_align: purely combinational be/wdata generation, load extraction/extension and misalign detection.
- FSM, timeout counter and MEM/WB register remain in the top module.

Test Plan:
1. Reset: hold reset_i=0 two cycles with Mem_Rd_i=1 -> dmem_req_o=0, stall_o=0, all MEM/WB outputs 0.
2. LW zero-wait:
   - Stimulus: addr 0x100, funct3=010, dmem_ready_i=1, rdata 0xDEADBEEF, RegD_i=5, M_to_R_i=1.
   - Response: stall_o=0; next cycle Mem_data_o=0xDEADBEEF, RegD_o=5, Reg_w_o=1.
3. LB and LBU:
   - LB at 0x103, rdata 0x80112233 -> Mem_data_o=0xFFFFFF80.
   - LBU at the same address -> 0x00000080.
   - LHU at 0x102 -> 0x00008011.
4. SH with wait states:
   - Stimulus: addr 0x202, data 0x00001234, dmem_ready_i after 3 wait cycles.
   - Response: dmem_addr_o=0x200, be=1100, wdata=0x12341234, we=1; stall_o high exactly 3 cycles; Reg_w_o=0 throughout.
5. Misaligned LW at 0x101 -> dmem_req_o=0, stall_o=0, misalign_o pulses one cycle, Reg_w_o=0.
6. Timeout and reset mid-WAIT:
   - dmem_ready_i never asserted -> stall_o high TIMEOUT cycles, then bus_err_o pulse, Reg_w_o=0, FSM back to IDLE.
   - Repeat with reset_i=0 in cycle 4 of WAIT -> dmem_req_o=0 immediately, no bus_err_o.
